// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM/WB valid/ready pipeline stage with skid buffer
// Formats load data, selects the writeback source, and counts retired beats.
module mem_wb_pipe #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_alu_data,
  input  logic [XLEN-1:0]           in_mem_rdata,
  input  logic [XLEN-1:0]           in_link_data,
  input  logic [1:0]                in_wb_sel,
  input  logic [$clog2(XLEN/8)-1:0] in_byte_off,
  input  logic [1:0]                in_ld_size,
  input  logic                      in_ld_unsigned,
  input  logic [RADDR_W-1:0]        in_rd,
  input  logic                      in_regwrite,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_wb_data,
  output logic [RADDR_W-1:0]        out_rd,
  output logic                      out_regwrite,
  output logic [RADDR_W-1:0]        fwd_rd,
  output logic                      fwd_regwrite,
  output logic [XLEN-1:0]           fwd_data,
  output logic [CNT_W-1:0]          retire_cnt
);

  localparam int OFF_W = $clog2(XLEN/8);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]    data;
    logic [RADDR_W-1:0] rd;
    logic               rw;
  } beat_t;

  state_t           r_state;
  beat_t            r_main;
  beat_t            r_skid;
  logic [CNT_W-1:0] r_cnt;

  logic [OFF_W-1:0] w_off;
  logic [XLEN-1:0]  w_sh;
  logic [XLEN-1:0]  w_ld;
  beat_t            w_in_beat;
  logic             w_accept;
  logic             w_drain;

  // Sub-size accesses snap the offset down to their natural alignment.
  always_comb begin
    w_off = in_byte_off;
    case (in_ld_size)
      2'd0: w_off = in_byte_off;
      2'd1: w_off[0] = 1'b0;
      2'd2: w_off[1:0] = 2'b00;
      default: w_off = '0;
    endcase
  end

  assign w_sh = in_mem_rdata >> {w_off, 3'b000};

  // Size 3 on a 32-bit datapath resolves to the full word, i.e. a word load.
  always_comb begin
    w_ld = w_sh;
    case (in_ld_size)
      2'd0: begin
        w_ld = {XLEN{~in_ld_unsigned & w_sh[7]}};
        w_ld[7:0] = w_sh[7:0];
      end
      2'd1: begin
        w_ld = {XLEN{~in_ld_unsigned & w_sh[15]}};
        w_ld[15:0] = w_sh[15:0];
      end
      2'd2: begin
        w_ld = {XLEN{~in_ld_unsigned & w_sh[31]}};
        w_ld[31:0] = w_sh[31:0];
      end
      default: w_ld = w_sh;
    endcase
  end

  always_comb begin
    case (in_wb_sel)
      2'b01:   w_in_beat.data = w_ld;
      2'b10:   w_in_beat.data = in_link_data;
      default: w_in_beat.data = in_alu_data;
    endcase
    w_in_beat.rd = in_rd;
    w_in_beat.rw = in_regwrite & (in_rd != '0);
  end

  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_drain)
        r_cnt <= r_cnt + CNT_W'(1);
      if (flush) begin
        r_state <= S_EMPTY;
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_accept) begin
              r_main  <= w_in_beat;
              r_state <= S_ONE;
            end
          end
          S_ONE: begin
            if (w_accept && !w_drain) begin
              r_skid  <= w_in_beat;
              r_state <= S_FULL;
            end else if (w_accept && w_drain) begin
              r_main <= w_in_beat;
            end else if (w_drain) begin
              r_state <= S_EMPTY;
            end
          end
          S_FULL: begin
            if (w_drain) begin
              r_main  <= r_skid;
              r_state <= S_ONE;
            end
          end
          default: r_state <= S_EMPTY;
        endcase
      end
    end
  end

  assign out_wb_data  = r_main.data;
  assign out_rd       = r_main.rd;
  assign out_regwrite = r_main.rw;
  assign fwd_rd       = r_main.rd;
  assign fwd_data     = r_main.data;
  assign fwd_regwrite = out_valid & r_main.rw;
  assign retire_cnt   = r_cnt;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - scoreboard bench for mem_wb_pipe
// Expected beats are queued on accept and checked in order on drain.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_alu_data;
  logic [63:0] in_mem_rdata;
  logic [63:0] in_link_data;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_byte_off;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_wb_data;
  logic [4:0]  out_rd;
  logic        out_regwrite;
  logic [4:0]  fwd_rd;
  logic        fwd_regwrite;
  logic [63:0] fwd_data;
  logic [3:0]  retire_cnt;

  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t q[$];
  exp_t exp_cur;
  int   vectors = 0;
  int   miscompares = 0;
  int   cnt = 0;
  bit   last_acc;

  mem_wb_pipe #(.XLEN(64), .RADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_data(in_alu_data), .in_mem_rdata(in_mem_rdata), .in_link_data(in_link_data),
    .in_wb_sel(in_wb_sel), .in_byte_off(in_byte_off), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .out_valid(out_valid), .out_ready(out_ready), .out_wb_data(out_wb_data),
    .out_rd(out_rd), .out_regwrite(out_regwrite),
    .fwd_rd(fwd_rd), .fwd_regwrite(fwd_regwrite), .fwd_data(fwd_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] mem,
                       input logic [63:0] link, input logic [2:0] off, input logic [1:0] size,
                       input logic uns, input logic [4:0] rd, input logic rw,
                       input logic [63:0] exp_d, input logic exp_rw);
    in_valid = 1'b1;
    in_wb_sel = sel; in_alu_data = alu; in_mem_rdata = mem; in_link_data = link;
    in_byte_off = off; in_ld_size = size; in_ld_unsigned = uns;
    in_rd = rd; in_regwrite = rw;
    exp_cur = '{d: exp_d, rd: rd, rw: exp_rw};
  endtask

  task automatic alu_beat(input logic [63:0] v, input logic [4:0] rd);
    drive(2'b00, v, 64'h0, 64'h0, 3'd0, 2'd0, 1'b0, rd, 1'b1, v, rd != 5'd0);
  endtask

  // Called just after a falling edge with inputs set; advances one full cycle.
  task automatic tick();
    bit acc, drn;
    exp_t h;
    #1;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("retire_cnt", retire_cnt, 64'(cnt & 15));
    if (q.size() > 0) begin
      h = q[0];
      chk("out_wb_data", out_wb_data, h.d);
      chk("out_rd", out_rd, h.rd);
      chk("out_regwrite", out_regwrite, h.rw);
      chk("fwd_data", fwd_data, h.d);
      chk("fwd_rd", fwd_rd, h.rd);
      chk("fwd_regwrite", fwd_regwrite, h.rw);
    end
    acc = in_valid && (q.size() < 2);
    drn = out_ready && (q.size() > 0);
    if (drn) begin
      void'(q.pop_front());
      cnt++;
    end
    if (flush) q.delete();
    else if (acc) q.push_back(exp_cur);
    last_acc = acc && !flush;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain_all();
    int guard = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_alu_data = '0; in_mem_rdata = '0; in_link_data = '0; in_wb_sel = '0;
    in_byte_off = '0; in_ld_size = '0; in_ld_unsigned = 1'b0; in_rd = '0; in_regwrite = 1'b0;
    exp_cur = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wb_data", out_wb_data, 0);
    chk("rst_rd", out_rd, 0);
    chk("rst_regwrite", out_regwrite, 0);
    chk("rst_cnt", retire_cnt, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load formatting and source select, streaming with out_ready high.
    out_ready = 1'b1;
    drive(2'b01, 64'h0, 64'h8877665544332211, 64'h0, 3'd7, 2'd0, 1'b0, 5'd1, 1'b1, 64'hFFFFFFFFFFFFFF88, 1'b1); tick();
    drive(2'b01, 64'h0, 64'h8877665544332211, 64'h0, 3'd7, 2'd0, 1'b1, 5'd1, 1'b1, 64'h88, 1'b1); tick();
    drive(2'b01, 64'h0, 64'h0000000080010000, 64'h0, 3'd3, 2'd1, 1'b0, 5'd2, 1'b1, 64'hFFFFFFFFFFFF8001, 1'b1); tick();
    drive(2'b01, 64'h0, 64'h7FFF000000000000, 64'h0, 3'd4, 2'd2, 1'b0, 5'd3, 1'b1, 64'h000000007FFF0000, 1'b1); tick();
    drive(2'b01, 64'h0, 64'h0123456789ABCDEF, 64'h0, 3'd5, 2'd3, 1'b0, 5'd4, 1'b1, 64'h0123456789ABCDEF, 1'b1); tick();
    drive(2'b01, 64'h0, 64'h00000000F0000000, 64'h0, 3'd1, 2'd2, 1'b1, 5'd6, 1'b1, 64'h00000000F0000000, 1'b1); tick();
    drive(2'b10, 64'h5, 64'h0, 64'h1004, 3'd0, 2'd0, 1'b0, 5'd1, 1'b1, 64'h1004, 1'b1); tick();
    drive(2'b11, 64'h77, 64'h0, 64'h1004, 3'd0, 2'd0, 1'b0, 5'd7, 1'b0, 64'h77, 1'b0); tick();
    drain_all();

    // Backpressure: third beat must wait for the skid to free up.
    out_ready = 1'b0;
    alu_beat(64'd1, 5'd2); tick();
    alu_beat(64'd2, 5'd2); tick();
    alu_beat(64'd3, 5'd2); tick();
    chk("bp_beat3_held", last_acc, 0);
    out_ready = 1'b1;
    guard = 0;
    last_acc = 1'b0;
    while (!last_acc && guard < 10) begin
      tick();
      guard++;
    end
    chk("bp_beat3_accepted", last_acc, 1);
    drain_all();
    #1 chk("bp_retire", retire_cnt, 64'((8 + 3) & 15));

    // x0 never writes or forwards; a real rd does.
    alu_beat(64'hDEAD, 5'd0); tick();
    alu_beat(64'hDEAD, 5'd5); tick();
    drain_all();

    // Flush while FULL with a new beat offered.
    out_ready = 1'b0;
    alu_beat(64'hA1, 5'd8); tick();
    alu_beat(64'hA2, 5'd9); tick();
    flush = 1'b1;
    alu_beat(64'h99, 5'd10); tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flush_cnt", retire_cnt, 64'((8 + 3 + 2) & 15));

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    alu_beat(64'hBEEF, 5'd11); tick();
    alu_beat(64'hCAFE, 5'd12); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_wb_data", out_wb_data, 0);
    chk("arst_regwrite", out_regwrite, 0);
    chk("arst_cnt", retire_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
    cnt = 0;
    alu_beat(64'h55, 5'd13);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    alu_beat(64'h66, 5'd14); tick();
    in_valid = 1'b0; tick();
    tick();

    // Counter wrap: 17 drains from reset lands on 1 with a 4-bit counter.
    for (int i = 1; i < 17; i++) begin
      alu_beat(64'(i * 3), 5'd15);
      tick();
    end
    drain_all();
    #1 chk("wrap_cnt", retire_cnt, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
